// File: rtl/gcd_host_sequencer_if.sv
// Operand, result and engine-side signals of the GCD host sequencer.
// master = sequencer side, slave = the surrounding system (source, sink and engine).
interface gcd_host_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_gcd;
    logic             res_err;
    logic             eng_start;
    logic [WIDTH-1:0] eng_data;
    logic             eng_done;
    logic [WIDTH-1:0] eng_gcd;

    modport master (
        input  in_valid, in_a, in_b, res_ready, eng_done, eng_gcd,
        output in_ready, res_valid, res_gcd, res_err, eng_start, eng_data
    );

    modport slave (
        output in_valid, in_a, in_b, res_ready, eng_done, eng_gcd,
        input  in_ready, res_valid, res_gcd, res_err, eng_start, eng_data
    );
endinterface

// File: rtl/gcd_host_sequencer.sv
// Drives the subtraction GCD engine for one operand pair at a time; result 5 cycles after accept at best, 1 for zero operands.
// in_ready only in IDLE; result is held in RESP until res_ready, with a watchdog error if the engine never finishes.
module gcd_host_sequencer #(
    parameter int WIDTH = 16,
    parameter int TO_W  = 18
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gcd_host_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, WAIT, RESP} state_t;

    localparam logic [TO_W-1:0] WD_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    state_t           state;
    logic [WIDTH-1:0] b_q;
    logic [TO_W-1:0]  wd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            b_q           <= '0;
            wd            <= '0;
            bus.in_ready  <= 1'b1;
            bus.res_valid <= 1'b0;
            bus.res_gcd   <= '0;
            bus.res_err   <= 1'b0;
            bus.eng_start <= 1'b0;
            bus.eng_data  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        b_q          <= bus.in_b;
                        bus.in_ready <= 1'b0;
                        if (bus.in_a == '0 || bus.in_b == '0) begin
                            state         <= RESP;
                            bus.res_gcd   <= bus.in_a | bus.in_b;
                            bus.res_err   <= 1'b0;
                            bus.res_valid <= 1'b1;
                        end else begin
                            state         <= LOAD_A;
                            bus.eng_start <= 1'b1;
                            bus.eng_data  <= bus.in_a;
                        end
                    end
                end
                LOAD_A: begin
                    state         <= LOAD_B;
                    bus.eng_start <= 1'b0;
                    bus.eng_data  <= b_q;
                end
                LOAD_B: begin
                    state <= WAIT;
                    wd    <= '0;
                end
                WAIT: begin
                    wd <= wd + 1'b1;
                    // wd==0 marks the first WAIT cycle, where done may still be left over from the previous pair
                    if (wd != '0 && bus.eng_done) begin
                        state         <= RESP;
                        bus.res_gcd   <= bus.eng_gcd;
                        bus.res_err   <= 1'b0;
                        bus.res_valid <= 1'b1;
                        bus.eng_data  <= '0;
                    end else if (wd == WD_LAST) begin
                        state         <= RESP;
                        bus.res_gcd   <= '0;
                        bus.res_err   <= 1'b1;
                        bus.res_valid <= 1'b1;
                        bus.eng_data  <= '0;
                    end
                end
                RESP: begin
                    if (bus.res_ready) begin
                        state         <= IDLE;
                        bus.res_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gcd_host_sequencer.sv
// Directed and random checks of gcd_host_sequencer against a behavioural subtraction engine.
module tb_gcd_host_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    gcd_host_sequencer_if #(.WIDTH(16)) bus ();
    gcd_host_sequencer_if #(.WIDTH(16)) bus_to ();

    gcd_host_sequencer #(.WIDTH(16), .TO_W(18)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    gcd_host_sequencer #(.WIDTH(16), .TO_W(4)) dut_to (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_to.master)
    );

    int n_tests   = 0;
    int n_fail    = 0;
    int start_cnt = 0;

    // Engine model: no reset, done stays at its old value until the first subtraction step.
    logic [15:0] ea = '0, eb = '0, gcd_r = '0;
    logic        ld_b = 1'b0, busy = 1'b0, done_r = 1'b0;

    always @(posedge clk) begin
        if (bus.eng_start) begin
            ea   <= bus.eng_data;
            ld_b <= 1'b1;
            busy <= 1'b0;
        end else if (ld_b) begin
            eb   <= bus.eng_data;
            ld_b <= 1'b0;
            busy <= 1'b1;
        end else if (busy) begin
            if (ea == eb) begin
                done_r <= 1'b1;
                gcd_r  <= ea;
                busy   <= 1'b0;
            end else begin
                done_r <= 1'b0;
                if (ea > eb) ea <= ea - eb;
                else         eb <= eb - ea;
            end
        end
    end

    assign bus.eng_done    = done_r;
    assign bus.eng_gcd     = gcd_r;
    assign bus_to.eng_done = 1'b0;
    assign bus_to.eng_gcd  = '0;

    always @(negedge clk) if (bus.eng_start) start_cnt++;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic send(input logic [15:0] a, input logic [15:0] b);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) check_eq("accept_timeout", 0, 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.res_valid && lat < 4000);
        if (!bus.res_valid) check_eq("res_valid_timeout", 0, 1);
    endtask

    task automatic take(output logic [15:0] g, output logic e, output int lat);
        wait_valid(lat);
        g = bus.res_gcd;
        e = bus.res_err;
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1 bus.res_ready = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [15:0] g, a, b;
        logic        e;
        int          lat, s0, exp, n;
        bit          got;

        rst_n            = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_a         = '0;
        bus.in_b         = '0;
        bus.res_ready    = 1'b0;
        bus_to.in_valid  = 1'b0;
        bus_to.in_a      = '0;
        bus_to.in_b      = '0;
        bus_to.res_ready = 1'b1;

        #22;
        check_eq("rst_in_ready",  bus.in_ready,  1);
        check_eq("rst_res_valid", bus.res_valid, 0);
        check_eq("rst_res_gcd",   bus.res_gcd,   0);
        check_eq("rst_res_err",   bus.res_err,   0);
        check_eq("rst_eng_start", bus.eng_start, 0);
        check_eq("rst_eng_data",  bus.eng_data,  0);
        @(negedge clk);
        rst_n = 1'b1;

        // 48,18: one start pulse, A then B on the data bus
        s0 = start_cnt;
        send(16'd48, 16'd18);
        @(negedge clk);
        check_eq("la_start",    bus.eng_start, 1);
        check_eq("la_data",     bus.eng_data,  48);
        check_eq("la_in_ready", bus.in_ready,  0);
        @(negedge clk);
        check_eq("lb_start", bus.eng_start, 0);
        check_eq("lb_data",  bus.eng_data,  18);
        @(negedge clk);
        check_eq("wait_data", bus.eng_data, 18);
        take(g, e, lat);
        check_eq("g48_18",      g, 6);
        check_eq("e48_18",      e, 0);
        check_eq("start_once",  start_cnt - s0, 1);

        // 5,5: earliest result at T+5; stale done (gcd 6) present in the first WAIT cycle
        send(16'd5, 16'd5);
        take(g, e, lat);
        check_eq("g5_5_lat", lat, 5);
        check_eq("g5_5",     g,   5);
        @(negedge clk);
        check_eq("idle_in_ready", bus.in_ready,  1);
        check_eq("idle_valid",    bus.res_valid, 0);
        check_eq("idle_data",     bus.eng_data,  0);

        // zero-operand bypass
        s0 = start_cnt;
        send(16'd0, 16'd7);
        take(g, e, lat);
        check_eq("z0_7_lat", lat, 1);
        check_eq("z0_7",     g,   7);
        check_eq("z0_7_err", e,   0);
        send(16'd0, 16'd0);
        take(g, e, lat);
        check_eq("z0_0", g, 0);
        send(16'd9, 16'd0);
        take(g, e, lat);
        check_eq("z9_0_lat", lat, 1);
        check_eq("z9_0",     g,   9);
        check_eq("z_no_start", start_cnt - s0, 0);

        // 35,21 with res_ready held low and a competing pair offered
        send(16'd35, 16'd21);
        wait_valid(lat);
        bus.in_valid = 1'b1;
        bus.in_a     = 16'd3;
        bus.in_b     = 16'd3;
        s0 = start_cnt;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("bp_valid",    bus.res_valid, 1);
            check_eq("bp_gcd",      bus.res_gcd,   7);
            check_eq("bp_in_ready", bus.in_ready,  0);
        end
        check_eq("bp_no_start", start_cnt - s0, 0);
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1 bus.res_ready = 1'b0;
        @(negedge clk);
        check_eq("bp_released", bus.res_valid, 0);

        // watchdog on the TO_W=4 instance with done stuck low
        @(negedge clk);
        bus_to.in_valid = 1'b1;
        bus_to.in_a     = 16'd9;
        bus_to.in_b     = 16'd6;
        @(posedge clk);
        #1 bus_to.in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_to.res_valid && n < 100);
        check_eq("to_lat", n,              18);
        check_eq("to_err", bus_to.res_err, 1);
        check_eq("to_gcd", bus_to.res_gcd, 0);

        // asynchronous reset in the middle of WAIT
        send(16'd1000, 16'd1);
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_in_ready", bus.in_ready,  1);
        check_eq("mid_rst_valid",    bus.res_valid, 0);
        check_eq("mid_rst_gcd",      bus.res_gcd,   0);
        check_eq("mid_rst_err",      bus.res_err,   0);
        check_eq("mid_rst_start",    bus.eng_start, 0);
        check_eq("mid_rst_data",     bus.eng_data,  0);
        @(negedge clk);
        rst_n = 1'b1;
        send(16'd100, 16'd75);
        take(g, e, lat);
        check_eq("g100_75", g, 25);
        check_eq("e100_75", e, 0);

        // random pairs with random result backpressure
        for (int i = 0; i < 50; i++) begin
            a   = 16'($urandom_range(1, 1000));
            b   = 16'($urandom_range(1, 1000));
            exp = ref_gcd(int'(a), int'(b));
            send(a, b);
            lat = 0;
            got = 1'b0;
            while (!got && lat < 4000) begin
                @(negedge clk);
                lat++;
                bus.res_ready = 1'($urandom_range(0, 1));
                got = bus.res_valid && bus.res_ready;
            end
            if (!got) check_eq("rnd_timeout", 0, 1);
            check_eq("rnd_gcd", bus.res_gcd, exp);
            check_eq("rnd_err", bus.res_err, 0);
            @(posedge clk);
            #1 bus.res_ready = 1'b0;
            @(negedge clk);
            check_eq("rnd_nodup", bus.res_valid, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/gcd_host_sequencer.md
# gcd_host_sequencer

Host-side driver for the repeated-subtraction GCD engine. Accepts operand pairs from an upstream valid/ready source and runs the engine's start/data_in/done protocol: pulse start, present A then B on the shared data bus, wait for done. Captures the GCD and returns it on a valid/ready result port. Zero operands are resolved locally, and a cycle watchdog flags an engine that never finishes.

## Interface
- WIDTH, 16, operand/result width; must match the engine bus width.
- TO_W, 18, watchdog counter width; timeout occurs after 2^TO_W − 1 WAIT cycles.

- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept a pair.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accepts result.
- res_gcd  out  WIDTH  GCD result.
- res_err  out  1  result is a timeout error; res_gcd=0 when set.
- eng_start  out  1  engine start pulse.
- eng_data  out  WIDTH  engine data_in bus.
- eng_done  in  1  engine done (level).
- eng_gcd  in  WIDTH  engine GCD output.

## Operation
- States: IDLE, LOAD_A, LOAD_B, WAIT, RESP.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register in_a/in_b.
  - If a==0 or b==0, go to RESP with res_gcd = a|b and res_err=0; 0,0 gives 0. The engine is not started.
  - Otherwise go to LOAD_A.
- LOAD_A: eng_start=1, eng_data=A; go to LOAD_B.
- LOAD_B: eng_start=0, eng_data=B; clear watchdog; go to WAIT.
- WAIT:
  - eng_data held at B.
  - The watchdog increments each cycle.
  - eng_done is ignored on the first WAIT cycle, to mask a stale done from a previous operation.
  - From the second WAIT cycle, eng_done=1 captures eng_gcd into res_gcd with res_err=0, then go to RESP.
  - If the watchdog reaches all-ones first, set res_gcd=0, res_err=1, and go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP:
  - res_valid=1; res_gcd and res_err are held stable.
  - On res_ready, go to IDLE.
- in_ready=0 in every state except IDLE. Only one operation is in flight at a time.
- eng_start is asserted only in LOAD_A; it is never asserted twice without an intervening WAIT or timeout.
- eng_data is 0 in IDLE and RESP.

## Timing
- Reset (async assert, sync-released by the system) sets:
  - state=IDLE, in_ready=1;
  - res_valid=0, res_gcd=0, res_err=0;
  - eng_start=0, eng_data=0;
  - watchdog=0.
- All outputs are registered or are decoded directly from the state register. There are no combinational input→output paths.
- Accept on cycle T:
  - LOAD_A at T+1 (eng_start=1);
  - LOAD_B at T+2;
  - WAIT from T+3.
- Earliest sampled done is at T+4, giving res_valid at T+5.
- Zero-operand bypass: res_valid at T+1.
- Result handshake completes on a cycle with res_valid&&res_ready. in_ready=1 on the next cycle, so there is 1 idle cycle between results.
- Reset mid-operation returns to IDLE immediately.
  - Any captured result is discarded.
  - The engine, which has no reset, may be left running. The first-WAIT-cycle done mask covers its stale done on the next operation.

## Test plan
- A=48, B=18 with a behavioural engine model → eng_start for exactly 1 cycle with eng_data=48, next cycle eng_data=18; res_gcd=6, res_err=0.
- A=0, B=7 → no eng_start; res_valid at T+1 with res_gcd=7. Also A=0, B=0 → res_gcd=0.
- A=35, B=21, res_ready held low 20 cycles → res_valid and res_gcd=7 stable; in_ready=0 throughout; in_valid is ignored.
- Engine stub with done stuck low, TO_W=4 → res_err=1, res_gcd=0 at 15 WAIT cycles. Done stuck high from a previous op → masked on the first WAIT cycle.
- rst_n pulsed low during WAIT → all outputs at reset values asynchronously. The next pair (100,75) → 25.
- 50 random back-to-back pairs (nonzero, ≤ 1000) with random res_ready → every result matches the reference GCD, in order, with no dropped or duplicated results.
